// File: rtl/vc_arb_pkg.sv
// vc_arb_pkg: shared definitions for the VC-to-destination arbiter.
//   - state_t: FSM state encoding (RESET=0 .. ERROR=4), visible on the
//     arbiter's `state` port.
//   - Default word width, routing-bit index and threshold reset values.
// No ports (package).
package vc_arb_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  localparam int DATA_SIZE_DEFAULT = 6;
  localparam int DEST_BIT_DEFAULT  = 4;
  localparam int AF_DEFAULT_VAL    = 3;
  localparam int AE_DEFAULT_VAL    = 1;

endpackage

// File: rtl/vc_dest_arbiter_if.sv
// vc_dest_arbiter_if: FIFO-facing bus of the arbiter.
//   VC side : vc0/vc1_empty, vc0/vc1_data (FWFT heads), pop_vc0/pop_vc1
//   Dest side: pause_d0/pause_d1, push_d0/push_d1, data_d0/data_d1
// Modports:
//   master - the arbiter (drives pops, pushes and push data)
//   slave  - the FIFO side (drives empties, heads and pause flags)
interface vc_dest_arbiter_if #(
  parameter int DATA_SIZE = vc_arb_pkg::DATA_SIZE_DEFAULT
);
  logic                 vc0_empty;
  logic                 vc1_empty;
  logic [DATA_SIZE-1:0] vc0_data;
  logic [DATA_SIZE-1:0] vc1_data;
  logic                 pop_vc0;
  logic                 pop_vc1;
  logic                 pause_d0;
  logic                 pause_d1;
  logic                 push_d0;
  logic                 push_d1;
  logic [DATA_SIZE-1:0] data_d0;
  logic [DATA_SIZE-1:0] data_d1;

  modport master (
    input  vc0_empty, vc1_empty, vc0_data, vc1_data, pause_d0, pause_d1,
    output pop_vc0, pop_vc1, push_d0, push_d1, data_d0, data_d1
  );

  modport slave (
    output vc0_empty, vc1_empty, vc0_data, vc1_data, pause_d0, pause_d1,
    input  pop_vc0, pop_vc1, push_d0, push_d1, data_d0, data_d1
  );
endinterface

// File: rtl/vc_grant.sv
// vc_grant: pure combinational grant between the two VCs.
//   elig[1:0]  in  : per-VC eligibility (bit0 = vc0, bit1 = vc1)
//   last_vc1   in  : 1 when the most recent grant went to vc1
//   grant[1:0] out : one-hot grant, 0 when nothing is eligible
// Build option ARB_ROUND_ROBIN_EN: alternate on contention; otherwise
// vc0 has strict priority.
module vc_grant (
  input  logic [1:0] elig,
  input  logic       last_vc1,
  output logic [1:0] grant
);

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    grant = 2'b00;
    if (elig == 2'b11) begin
      // Contention: favour whichever VC did not win last time.
      grant = last_vc1 ? 2'b01 : 2'b10;
    end else begin
      grant = elig;
    end
  end
`else
  logic unused_last_vc1;
  assign unused_last_vc1 = last_vc1;

  always_comb begin
    grant = 2'b00;
    if (elig[0]) begin
      grant = 2'b01;
    end else if (elig[1]) begin
      grant = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/vc_dest_arbiter.sv
// vc_dest_arbiter: pops one word per cycle from an eligible VC FIFO and
// pushes it, one cycle later, into the destination FIFO chosen by the
// word's DEST_BIT. Thresholds for the destination FIFOs are latched while
// in INIT; any reported FIFO error parks the FSM in ERROR until reset.
// Ports:
//   clk, reset_L (sync, active low), init
//   umbral_af, umbral_ae : thresholds loaded during INIT
//   error_in             : OR of all FIFO error flags
//   bus (master)         : VC pops/heads, destination pushes/data/pause
//   afD_o, aeD_o         : latched thresholds
//   state, idle          : FSM state and quiescent flag
//   pkt_count            : forwarded word count, wraps at 256
// Build option ARB_ROUND_ROBIN_EN selects round-robin arbitration in vc_grant.
module vc_dest_arbiter
  import vc_arb_pkg::*;
#(
  parameter int DATA_SIZE  = DATA_SIZE_DEFAULT,
  parameter int DEST_BIT   = DEST_BIT_DEFAULT,
  parameter int AF_DEFAULT = AF_DEFAULT_VAL,
  parameter int AE_DEFAULT = AE_DEFAULT_VAL
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 init,
  input  logic [DATA_SIZE-1:0] umbral_af,
  input  logic [DATA_SIZE-1:0] umbral_ae,
  input  logic                 error_in,
  vc_dest_arbiter_if.master    bus,
  output logic [DATA_SIZE-1:0] afD_o,
  output logic [DATA_SIZE-1:0] aeD_o,
  output logic [2:0]           state,
  output logic                 idle,
  output logic [7:0]           pkt_count
);

  state_t               state_reg, state_next;
  logic [DATA_SIZE-1:0] vc_data [2];
  logic [1:0]           vc_empty;
  logic [1:0]           pause;
  logic [1:0]           elig;
  logic [1:0]           grant;
  logic                 pop_en;
  logic                 pop_any;
  logic [DATA_SIZE-1:0] pop_word;
  logic                 pop_dest;
  logic                 last_vc1_reg;
  logic                 push_d0_reg, push_d1_reg;
  logic [DATA_SIZE-1:0] data_d0_reg, data_d1_reg;
  logic [DATA_SIZE-1:0] afd_reg, aed_reg;
  logic [7:0]           pkt_count_reg;

  assign vc_data[0] = bus.vc0_data;
  assign vc_data[1] = bus.vc1_data;
  assign vc_empty   = {bus.vc1_empty, bus.vc0_empty};
  assign pause      = {bus.pause_d1, bus.pause_d0};

  // A VC is eligible when it has a word whose destination is not paused.
  for (genvar gi = 0; gi < 2; gi++) begin : g_elig
    assign elig[gi] = !vc_empty[gi] && !pause[vc_data[gi][DEST_BIT]];
  end

  // reset_L gates pops so no word is lost while the pipeline is being cleared.
  assign pop_en = reset_L && !error_in &&
                  (state_reg == ST_IDLE || state_reg == ST_ACTIVE);

  vc_grant u_grant (
    .elig     (elig & {2{pop_en}}),
    .last_vc1 (last_vc1_reg),
    .grant    (grant)
  );

  assign pop_any  = |grant;
  assign pop_word = grant[1] ? vc_data[1] : vc_data[0];
  assign pop_dest = pop_word[DEST_BIT];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RESET:  state_next = ST_INIT;
      ST_INIT: begin
        if (error_in)      state_next = ST_ERROR;
        else if (!init)    state_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (error_in)      state_next = ST_ERROR;
        else if (init)     state_next = ST_INIT;
        else if (pop_any)  state_next = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (error_in)                           state_next = ST_ERROR;
        else if (!pop_any && vc_empty == 2'b11) state_next = ST_IDLE;
      end
      ST_ERROR:  state_next = ST_ERROR;
      default:   state_next = ST_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_reg     <= ST_RESET;
      push_d0_reg   <= 1'b0;
      push_d1_reg   <= 1'b0;
      data_d0_reg   <= '0;
      data_d1_reg   <= '0;
      afd_reg       <= DATA_SIZE'(AF_DEFAULT);
      aed_reg       <= DATA_SIZE'(AE_DEFAULT);
      last_vc1_reg  <= 1'b1;
      pkt_count_reg <= 8'd0;
    end else begin
      state_reg   <= state_next;
      push_d0_reg <= pop_any && !pop_dest;
      push_d1_reg <= pop_any && pop_dest;
      if (pop_any && !pop_dest) data_d0_reg <= pop_word;
      if (pop_any && pop_dest)  data_d1_reg <= pop_word;
      // The count moves with the push register, so it already includes
      // the push being presented this cycle.
      if (pop_any) begin
        pkt_count_reg <= pkt_count_reg + 8'd1;
        last_vc1_reg  <= grant[1];
      end
      if (state_reg == ST_INIT) begin
        afd_reg <= umbral_af;
        aed_reg <= umbral_ae;
      end
    end
  end

  assign bus.pop_vc0 = grant[0];
  assign bus.pop_vc1 = grant[1];
  assign bus.push_d0 = push_d0_reg;
  assign bus.push_d1 = push_d1_reg;
  assign bus.data_d0 = data_d0_reg;
  assign bus.data_d1 = data_d1_reg;
  assign afD_o       = afd_reg;
  assign aeD_o       = aed_reg;
  assign state       = state_reg;
  assign idle        = (state_reg == ST_IDLE) && !push_d0_reg && !push_d1_reg;
  assign pkt_count   = pkt_count_reg;

endmodule
